// File: rtl/fp_norm_round.sv
// Post-add normalisation and round-to-nearest-even stage of the FMAC datapath.
// Stage 1 counts leading zeros, normalises the magnitude and adjusts the exponent.
// Stage 2 rounds, classifies overflow/underflow/zero and packs the result.
// Both stages use valid/ready flow control and keep full throughput.
`timescale 1ns/1ps
module fp_norm_round #(
    parameter int C_WIDTH         = 51,
    parameter int C_LEADONE_WIDTH = 6,
    parameter int C_EXP_WIDTH     = 8,
    parameter int C_MANT_WIDTH    = 23
) (
    input  logic                     clk_I,
    input  logic                     rst_I,
    input  logic                     valid_I,
    output logic                     ready_O,
    input  logic                     sign_I,
    input  logic [C_EXP_WIDTH+1:0]   exp_I,
    input  logic [C_WIDTH-1:0]       mant_I,
    output logic                     valid_O,
    input  logic                     ready_I,
    output logic                     sign_O,
    output logic [C_EXP_WIDTH-1:0]   exp_O,
    output logic [C_MANT_WIDTH-1:0]  mant_O,
    output logic                     ovf_O,
    output logic                     unf_O,
    output logic                     zero_O
);

    localparam int EW2 = C_EXP_WIDTH + 2;
    localparam int GRD = C_WIDTH - 2 - C_MANT_WIDTH;
    localparam logic [EW2:0] EXP_MAX = (EW2+1)'((2 ** C_EXP_WIDTH) - 1);

    // Pipeline enables
    logic s1_en;
    logic s2_en;

    // Stage 1 combinational results
    logic [C_LEADONE_WIDTH-1:0] lz;
    logic [C_WIDTH-1:0]         norm;
    logic [EW2-1:0]             e1;

    // Stage 1 registers; the hidden bit is not kept, zero is derived from it instead
    logic                       s1_valid;
    logic                       s1_sign;
    logic [EW2-1:0]             s1_exp;
    logic [C_WIDTH-2:0]         s1_norm;
    logic                       s1_zero;

    // Stage 2 combinational results
    logic [C_MANT_WIDTH-1:0]    frac;
    logic                       guard;
    logic                       sticky;
    logic                       inc;
    logic [C_MANT_WIDTH:0]      frac_sum;
    logic [EW2:0]               e2;
    logic [C_EXP_WIDTH-1:0]     n_exp;
    logic [C_MANT_WIDTH-1:0]    n_mant;
    logic                       n_ovf;
    logic                       n_unf;
    logic                       n_zero;

    assign s2_en   = ~valid_O | ready_I;
    assign s1_en   = ~s1_valid | s2_en;
    assign ready_O = s1_en;

    // Leading-zero count: the highest set bit wins; an all-zero input yields C_WIDTH
    always_comb begin
        lz = C_LEADONE_WIDTH'(C_WIDTH);
        for (int unsigned i = 0; i < C_WIDTH; i++) begin
            if (mant_I[i]) begin
                lz = C_LEADONE_WIDTH'(C_WIDTH - 1 - i);
            end
        end
    end

    assign norm = mant_I << lz;
    assign e1   = exp_I + EW2'(1) - EW2'(lz);

    // Round to nearest even, then classify in priority zero > overflow > underflow
    always_comb begin
        frac     = s1_norm[C_WIDTH-2 -: C_MANT_WIDTH];
        guard    = s1_norm[GRD];
        sticky   = |s1_norm[GRD-1:0];
        inc      = guard & (sticky | frac[0]);
        frac_sum = {1'b0, frac} + (C_MANT_WIDTH+1)'(inc);
        e2       = {s1_exp[EW2-1], s1_exp} + (EW2+1)'(frac_sum[C_MANT_WIDTH]);
        n_exp    = e2[C_EXP_WIDTH-1:0];
        n_mant   = frac_sum[C_MANT_WIDTH-1:0];
        n_ovf    = 1'b0;
        n_unf    = 1'b0;
        n_zero   = 1'b0;
        if (s1_zero) begin
            n_exp  = '0;
            n_mant = '0;
            n_zero = 1'b1;
        end else if ($signed(e2) >= $signed(EXP_MAX)) begin
            n_exp  = '1;
            n_mant = '0;
            n_ovf  = 1'b1;
        end else if (e2[EW2] || (e2 == '0)) begin
            n_exp  = '0;
            n_mant = '0;
            n_unf  = 1'b1;
        end
    end

    // Two-stage pipeline registers with synchronous reset
    always_ff @(posedge clk_I) begin
        if (rst_I) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_norm  <= '0;
            s1_zero  <= 1'b0;
            valid_O  <= 1'b0;
            sign_O   <= 1'b0;
            exp_O    <= '0;
            mant_O   <= '0;
            ovf_O    <= 1'b0;
            unf_O    <= 1'b0;
            zero_O   <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid <= valid_I;
                if (valid_I) begin
                    s1_sign <= sign_I;
                    s1_exp  <= e1;
                    s1_norm <= norm[C_WIDTH-2:0];
                    s1_zero <= ~norm[C_WIDTH-1];
                end
            end
            if (s2_en) begin
                valid_O <= s1_valid;
                if (s1_valid) begin
                    sign_O <= s1_sign;
                    exp_O  <= n_exp;
                    mant_O <= n_mant;
                    ovf_O  <= n_ovf;
                    unf_O  <= n_unf;
                    zero_O <= n_zero;
                end else begin
                    sign_O <= 1'b0;
                    exp_O  <= '0;
                    mant_O <= '0;
                    ovf_O  <= 1'b0;
                    unf_O  <= 1'b0;
                    zero_O <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Post-add normalisation and rounding stage of the FMAC datapath.
- Takes the unnormalised magnitude sum, with sign and pre-shift exponent, from the adder.
- Computes the leading-zero count internally, left-shifts to normalise and adjusts the exponent.
- Rounds to nearest-even and emits a packed sign/exponent/mantissa result with overflow, underflow and zero flags.
- Two registered stages with valid/ready flow control on both sides.

Parameters:
- C_WIDTH, 51, width of the unnormalised magnitude input.
- C_LEADONE_WIDTH, 6, width of the internal leading-zero count; must satisfy 2^C_LEADONE_WIDTH > C_WIDTH.
- C_EXP_WIDTH, 8, width of the biased output exponent.
- C_MANT_WIDTH, 23, output fraction width excluding the hidden bit; requires C_WIDTH >= C_MANT_WIDTH+3.

Ports:
- clk_I  in  1  clock; all state updates on the rising edge.
- rst_I  in  1  synchronous active-high reset.
- valid_I  in  1  input beat valid.
- ready_O  out  1  block can accept an input beat this cycle.
- sign_I  in  1  sign of the result.
- exp_I  in  C_EXP_WIDTH+2  two's-complement biased exponent. Input value = mant_I × 2^(exp_I − bias − (C_WIDTH−2)), so the binary point sits below bit C_WIDTH−2 and bit C_WIDTH−1 is the carry bit.
- mant_I  in  C_WIDTH  unnormalised magnitude.
- valid_O  out  1  output beat valid.
- ready_I  in  1  downstream accepts the output beat.
- sign_O  out  1  result sign.
- exp_O  out  C_EXP_WIDTH  biased result exponent.
- mant_O  out  C_MANT_WIDTH  result fraction.
- ovf_O  out  1  overflow; result forced to infinity.
- unf_O  out  1  underflow; result flushed to signed zero.
- zero_O  out  1  input magnitude was zero.

Behaviour:
- Reset:
  - On rst_I=1 at a rising edge, both stage-valid registers clear and all output registers go to 0 (valid_O=0, sign_O/exp_O/mant_O/flags=0).
  - In-flight beats are discarded; reset overrides any simultaneous accept.
  - ready_O=1 in the first cycle after reset is released.
- Flow control:
  - s2_en = ~s2_valid | ready_I; s1_en = ~s1_valid | s2_en; ready_O = s1_en. This combinational ready path is permitted.
  - An input is accepted when valid_I & ready_O.
  - Output transfers when valid_O & ready_I.
  - Output registers hold stable while valid_O=1 & ready_I=0.
  - No beat is dropped or duplicated.
  - Latency is exactly 2 cycles from accept to valid_O when ready_I is held high.
  - Throughput is 1 beat/cycle.
  - A full pipe that is simultaneously drained and refilled stays full.
- Stage 1 (normalise):
  - lz = number of leading zeros of mant_I, counted from bit C_WIDTH−1.
  - norm = mant_I << lz.
  - e1 = exp_I + 1 − lz, computed at C_EXP_WIDTH+2 bits signed.
  - Register sign, e1, norm and an is_zero flag (mant_I==0).
- Stage 2 (round and pack):
  - frac = norm[C_WIDTH−2 : C_WIDTH−1−C_MANT_WIDTH].
  - guard = norm[C_WIDTH−2−C_MANT_WIDTH].
  - sticky = OR of all lower bits.
  - RNE increment = guard & (sticky | frac[0]).
  - If the incremented frac carries out: frac=0 and e1=e1+1.
- Classification, priority order:
  - zero (mant_I==0): exp_O=0, mant_O=0, zero_O=1, sign preserved.
  - e ≥ 2^C_EXP_WIDTH−1: exp_O=all ones, mant_O=0, ovf_O=1.
  - e ≤ 0: exp_O=0, mant_O=0, unf_O=1.
  - Otherwise: normal output, all flags 0.
- Flags are registered with the data and qualified by valid_O; they are 0 when valid_O=0 after reset.

Test Plan:
- Reset, then drive mant_I=1<<49, exp_I=127, sign_I=0, ready_I=1 -> two cycles later valid_O=1, sign_O=0, exp_O=127, mant_O=0, all flags 0.
- mant_I=(1<<50)|(1<<27)|(1<<26), exp_I=127 -> exp_O=128, mant_O=2 (guard=1, lsb=1, rounds up). Same with the 1<<27 term removed -> mant_O=0 (tie to even).
- mant_I=1<<50, exp_I=254 -> exp_O=255, mant_O=0, ovf_O=1. Then mant_I=1<<40, exp_I=5 (e=−4) -> exp_O=0, mant_O=0, unf_O=1. Then mant_I=0, sign_I=1 -> zero_O=1, sign_O=1.
- Stream 6 back-to-back beats with ready_I=0 for cycles 2–5:
  - ready_O drops after 2 beats are held.
  - valid_O stays high with outputs stable.
  - After release, all 6 results emerge in order with no loss or duplication.
- Assert rst_I for one cycle while 2 beats are in flight -> next cycle valid_O=0, all outputs 0, ready_O=1; previously in-flight beats never appear.
